// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback stage of the miniCPU datapath.
// Holds the 2**ADDR_W-entry architectural register file behind a one-deep
// writeback buffer. Two combinational read ports bypass from the buffer.
// A zero flag and a retired-write counter are kept for debug visibility.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       asynchronous active-low reset
//   stop        1 = ignore new writes; a buffered write still commits
//   write_en    execute requests a register write this cycle
//   dstadd      destination register of the write
//   result      write data from execute
//   srcadd_1/2  read addresses
//   operand_1/2 read data (combinational, youngest value wins)
//   wb_valid    buffer holds an uncommitted write
//   wb_addr     buffered destination
//   wb_data     buffered data
//   zero_flag   last committed data was zero
//   retire_cnt  number of committed writes, wraps modulo 256
module writeback_regfile #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] dstadd,
  input  logic [DATA_W-1:0] result,
  input  logic [ADDR_W-1:0] srcadd_1,
  input  logic [ADDR_W-1:0] srcadd_2,
  output logic [DATA_W-1:0] operand_1,
  output logic [DATA_W-1:0] operand_2,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic [7:0]        retire_cnt
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned CNT_W = 8;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_zero_flag;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic w_r0_drop;
  logic w_capture;

  // Writes to R0 vanish entirely when R0 is hardwired to zero.
  assign w_r0_drop = ZERO_R0 && (dstadd == ADDR_W'(0));
  assign w_capture = write_en && !stop && !w_r0_drop;

  // Buffer commit into the array, then optional capture of the new write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_zero_flag  <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (r_wb_valid) begin
        r_regs[r_wb_addr] <= r_wb_data;
        r_zero_flag       <= (r_wb_data == DATA_W'(0));
        r_retire_cnt      <= r_retire_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= dstadd;
        r_wb_data  <= result;
      end else if (r_wb_valid) begin
        // Address/data hold; only the valid bit drops after a commit.
        r_wb_valid <= 1'b0;
      end
    end
  end

  // Read mux: hardwired R0 first, then buffer bypass, then the array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = r_regs[addr];
    if (r_wb_valid && (r_wb_addr == addr)) begin
      v = r_wb_data;
    end
    if (ZERO_R0 && (addr == ADDR_W'(0))) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    operand_1 = read_port(srcadd_1);
    operand_2 = read_port(srcadd_2);
  end

  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign zero_flag  = r_zero_flag;
  assign retire_cnt = r_retire_cnt;

endmodule
